// File: rtl/sr_cmd_gen.sv
// Debounced set/clear push-button front end; issues mutually exclusive fixed-width s/r pulses to an SR flip-flop.
// Press-to-pulse latency is DEBOUNCE_CYCLES+2 edges; presses arriving while busy wait in a one-deep pending bit per channel.
// Optional macro SR_CMD_CNT_EN adds an 8-bit saturating cmd_count output.
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int PULSE_CYCLES    = 2,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_btn,
    input  logic       clr_btn,
    output logic       s,
    output logic       r,
    output logic       conflict,
    output logic       busy
`ifdef SR_CMD_CNT_EN
    ,
    output logic [7:0] cmd_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SET_PULSE,
        ST_CLR_PULSE,
        ST_HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    // Channel index 0 is set, index 1 is clear.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_deb_q;
    logic [1:0]       r_pend;
    logic [CNT_W-1:0] r_dcnt [2];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] w_tmr_nxt;
    logic [1:0]       w_press;
    logic [1:0]       w_req;
    logic [1:0]       w_pend_nxt;
    logic             w_conf_nxt;

    logic             r_s;
    logic             r_r;
    logic             r_conflict;
    logic             r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_deb   <= 2'b00;
            r_deb_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= {clr_btn, set_btn};
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DEB_LAST) begin
                    r_deb[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_deb & ~r_deb_q;
    assign w_req   = w_press | r_pend;

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_pend_nxt  = r_pend | w_press;
        w_conf_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Every outstanding request is either taken or dropped as a conflict here.
                w_pend_nxt = 2'b00;
                w_tmr_nxt  = '0;
                if (w_req == 2'b11) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_conf_nxt  = 1'b1;
                end else if (w_req[0]) begin
                    w_state_nxt = ST_SET_PULSE;
                end else if (w_req[1]) begin
                    w_state_nxt = ST_CLR_PULSE;
                end
            end
            ST_SET_PULSE, ST_CLR_PULSE: begin
                if (r_tmr == PULSE_LAST) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                // The conflict cycle itself does not count toward the idle gap.
                if (!r_conflict) begin
                    if (r_tmr == HOLD_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_pend     <= 2'b00;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_pend     <= w_pend_nxt;
            r_s        <= (w_state_nxt == ST_SET_PULSE);
            r_r        <= (w_state_nxt == ST_CLR_PULSE);
            r_conflict <= w_conf_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign conflict = r_conflict;
    assign busy     = r_busy;

`ifdef SR_CMD_CNT_EN
    logic [7:0] r_cmd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_cnt <= 8'd0;
        end else if ((r_state == ST_IDLE) && (r_cmd_cnt != 8'hFF) &&
                     ((w_state_nxt == ST_SET_PULSE) || (w_state_nxt == ST_CLR_PULSE))) begin
            r_cmd_cnt <= r_cmd_cnt + 8'd1;
        end
    end

    assign cmd_count = r_cmd_cnt;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Randomised and directed bench for sr_cmd_gen against an interval-based reference model.
module tb_sr_cmd_gen;

    localparam int D = 4;
    localparam int P = 2;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_btn = 1'b0;
    logic clr_btn = 1'b0;
    logic s;
    logic r;
    logic conflict;
    logic busy;
`ifdef SR_CMD_CNT_EN
    logic [7:0] cmd_count;
`endif

    int total = 0;
    int bad   = 0;

    sr_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .PULSE_CYCLES(P),
        .HOLDOFF_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .set_btn(set_btn),
        .clr_btn(clr_btn),
        .s(s),
        .r(r),
        .conflict(conflict),
        .busy(busy)
`ifdef SR_CMD_CNT_EN
        ,
        .cmd_count(cmd_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: sample history per channel, debounced levels, and the
    // currently scheduled command as a kind plus start edge and busy horizon.
    int          m_e = 0;
    bit [15:0]   m_hist [2];
    bit          m_deb [2];
    bit          m_rose [2];
    bit          m_pend [2];
    bit          m_raw_prev [2];
    bit          m_rst_prev = 1'b1;
    int          m_kind = 0;          // 0 none, 1 set, 2 clear, 3 conflict
    int          m_start = 0;
    int          m_idle_from = 0;
    logic [3:0]  m_exp = 4'b0000;     // {s, r, conflict, busy}
`ifdef SR_CMD_CNT_EN
    int          m_cnt = 0;
`endif

    task automatic model_edge(input bit sb, input bit cb, input bit rb);
        bit raw [2];
        bit press [2];
        bit req [2];
        bit flip;
        bit sync_now;
        raw[0] = sb;
        raw[1] = cb;
        m_e++;
        if (rb) begin
            for (int i = 0; i < 2; i++) begin
                m_hist[i] = 16'h0;
                m_deb[i]  = 1'b0;
                m_rose[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_kind      = 0;
            m_idle_from = m_e;
`ifdef SR_CMD_CNT_EN
            m_cnt = 0;
`endif
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] = m_rose[i];
                sync_now = m_rst_prev ? 1'b0 : m_raw_prev[i];
                // The level flips once the last D synchronised samples all disagree with it.
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (m_hist[i][j] == m_deb[i]) flip = 1'b0;
                end
                m_rose[i] = flip && !m_deb[i];
                if (flip) m_deb[i] = !m_deb[i];
                m_hist[i] = {m_hist[i][14:0], sync_now};
            end
            if (m_e - 1 >= m_idle_from) begin
                req[0] = press[0] | m_pend[0];
                req[1] = press[1] | m_pend[1];
                m_pend[0] = 1'b0;
                m_pend[1] = 1'b0;
                if (req[0] && req[1]) begin
                    m_kind = 3; m_start = m_e; m_idle_from = m_e + H + 1;
                end else if (req[0] || req[1]) begin
                    m_kind = req[0] ? 1 : 2; m_start = m_e; m_idle_from = m_e + P + H;
`ifdef SR_CMD_CNT_EN
                    if (m_cnt < 255) m_cnt++;
`endif
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (press[i]) m_pend[i] = 1'b1;
                end
            end
        end
        m_rst_prev    = rb;
        m_raw_prev[0] = raw[0];
        m_raw_prev[1] = raw[1];
        m_exp[3] = (m_kind == 1) && (m_e >= m_start) && (m_e < m_start + P);
        m_exp[2] = (m_kind == 2) && (m_e >= m_start) && (m_e < m_start + P);
        m_exp[1] = (m_kind == 3) && (m_e == m_start);
        m_exp[0] = (m_e < m_idle_from);
    endtask

    // Inputs change on the falling edge; outputs are observed on the next falling edge.
    task automatic cyc(input bit sb, input bit cb, input bit rb);
        set_btn = sb;
        clr_btn = cb;
        rst     = rb;
        @(posedge clk);
        model_edge(sb, cb, rb);
        @(negedge clk);
    endtask

    task automatic settle();
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cyc(k[0], !k[0], 1'b1);
            total++;
            if ({s, r, conflict, busy} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0000", k, {s, r, conflict, busy});
            end
        end
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if ({s, r, conflict, busy} !== 4'b0000 || m_exp !== 4'b0000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=0000", k, {s, r, conflict, busy});
            end
        end
    endtask

    task automatic test_clean_set();
        logic [2:0] want;
        settle();
        for (int k = 0; k < 22; k++) begin
            cyc(k < 12, 1'b0, 1'b0);
            want = {(k == 6 || k == 7), 1'b0, (k >= 6 && k <= 9)};
            total++;
            if ({s, r, busy} !== want || {s, r, conflict, busy} !== m_exp) begin
                bad++;
                $display("FAIL clean_set k=%0d got_srb=%b want_srb=%b model=%b", k, {s, r, busy}, want, m_exp);
            end
        end
    endtask

    task automatic test_debounce_boundary();
        int s_cycles;
        settle();
        s_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(k < D - 1, 1'b0, 1'b0);
            if (s === 1'b1) s_cycles++;
            total++;
            if ({s, r, conflict, busy} !== m_exp) begin
                bad++;
                $display("FAIL glitch_model k=%0d got=%b want=%b", k, {s, r, conflict, busy}, m_exp);
            end
        end
        total++;
        if (s_cycles != 0) begin
            bad++;
            $display("FAIL glitch_filtered s_cycles=%0d want=0", s_cycles);
        end
        s_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(k < D, 1'b0, 1'b0);
            if (s === 1'b1) s_cycles++;
        end
        total++;
        if (s_cycles != P) begin
            bad++;
            $display("FAIL exact_d_press s_cycles=%0d want=%0d", s_cycles, P);
        end
    endtask

    task automatic test_bounce();
        bit pat [7] = '{1, 1, 1, 0, 1, 1, 0};
        int rises;
        logic prev_s;
        settle();
        for (int k = 0; k < 17; k++) begin
            cyc((k < 7) ? pat[k] : 1'b0, 1'b0, 1'b0);
            total++;
            if ({s, busy} !== 2'b00 || {s, r, conflict, busy} !== m_exp) begin
                bad++;
                $display("FAIL bounce_quiet k=%0d got_sb=%b want_sb=00", k, {s, busy});
            end
        end
        rises  = 0;
        prev_s = 1'b0;
        for (int k = 0; k < 24; k++) begin
            cyc(k < 10, 1'b0, 1'b0);
            if (s === 1'b1 && prev_s === 1'b0) rises++;
            prev_s = s;
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL bounce_then_clean s_pulses=%0d want=1", rises);
        end
    endtask

    task automatic test_simultaneous();
        int n_conf;
        int n_busy;
        int n_sr;
        settle();
        n_conf = 0; n_busy = 0; n_sr = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(k < 8, k < 8, 1'b0);
            if (conflict === 1'b1) n_conf++;
            if (busy === 1'b1) n_busy++;
            if (s === 1'b1 || r === 1'b1) n_sr++;
            total++;
            if ({s, r, conflict, busy} !== m_exp) begin
                bad++;
                $display("FAIL simul_model k=%0d got=%b want=%b", k, {s, r, conflict, busy}, m_exp);
            end
        end
        total++;
        if (n_conf != 1 || n_busy != 3 || n_sr != 0) begin
            bad++;
            $display("FAIL simul_counts conf=%0d busy=%0d sr=%0d want 1 3 0", n_conf, n_busy, n_sr);
        end
    endtask

    task automatic test_pending();
        int n_s;
        int n_r;
        int last_s;
        int first_r;
        settle();
        n_s = 0; n_r = 0; last_s = -1; first_r = -1;
        for (int k = 0; k < 26; k++) begin
            cyc(k < 8, (k >= 2 && k < 10), 1'b0);
            if (s === 1'b1) begin n_s++; last_s = k; end
            if (r === 1'b1) begin n_r++; if (first_r < 0) first_r = k; end
            total++;
            if ({s, r, conflict, busy} !== m_exp) begin
                bad++;
                $display("FAIL pending_model k=%0d got=%b want=%b", k, {s, r, conflict, busy}, m_exp);
            end
        end
        total++;
        if (n_s != P || n_r != P || first_r <= last_s + H) begin
            bad++;
            $display("FAIL pending_order s=%0d r=%0d last_s=%0d first_r=%0d", n_s, n_r, last_s, first_r);
        end
    endtask

    task automatic test_reset_mid_pulse();
        settle();
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0);
        total++;
        if (r !== 1'b1) begin
            bad++;
            $display("FAIL mid_pulse_r_high got=%b want=1", r);
        end
        cyc(1'b0, 1'b1, 1'b1);
        total++;
        if ({r, busy} !== 2'b00) begin
            bad++;
            $display("FAIL mid_pulse_truncated got_rb=%b want=00", {r, busy});
        end
`ifdef SR_CMD_CNT_EN
        total++;
        if (cmd_count !== 8'd0) begin
            bad++;
            $display("FAIL mid_pulse_count got=%0d want=0", cmd_count);
        end
`endif
        settle();
    endtask

    task automatic test_random();
        int hold_s = 0;
        int hold_c = 0;
        bit lv_s = 1'b0;
        bit lv_c = 1'b0;
        bit rb;
        for (int k = 0; k < 1200; k++) begin
            if (hold_s == 0) begin lv_s = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 10); end
            if (hold_c == 0) begin lv_c = 1'($urandom_range(0, 1)); hold_c = $urandom_range(1, 10); end
            hold_s--;
            hold_c--;
            rb = ($urandom_range(0, 99) == 0);
            cyc(lv_s, lv_c, rb);
            total++;
            if ({s, r, conflict, busy} !== m_exp) begin
                bad++;
                $display("FAIL random_model e=%0d got=%b want=%b", m_e, {s, r, conflict, busy}, m_exp);
            end
        end
        settle();
    endtask

`ifdef SR_CMD_CNT_EN
    task automatic test_counter();
        cyc(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 14; k++) cyc(k < 6, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++) cyc(1'b0, k < 6, 1'b0);
        total++;
        if (cmd_count !== 8'd2 || m_cnt != 2) begin
            bad++;
            $display("FAIL count_two got=%0d want=2", cmd_count);
        end
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 14; k++) cyc(k < 6, 1'b0, 1'b0);
        end
        total++;
        if (cmd_count !== 8'd255 || m_cnt != 255) begin
            bad++;
            $display("FAIL count_saturate got=%0d want=255", cmd_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_set();
        test_debounce_boundary();
        test_bounce();
        test_simultaneous();
        test_pending();
        test_reset_mid_pulse();
        test_random();
`ifdef SR_CMD_CNT_EN
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
